// File: rtl/mul5_sched_if.sv
// mul5_sched_if
// Bundles the operand request ports of both requesters, the product result
// port and the busy flag of the mul5_sched scheduler.
//   req0_*/req1_* : valid/ready operand handshakes (a = multiplicand,
//                   b = multiplier, both 5-bit unsigned)
//   out_*         : valid/ready product handshake (10-bit product + id)
//   busy          : scheduler is working on or holding a job
// The slave modport is the scheduler's view; master is the view of whoever
// drives the operands and consumes the products.
interface mul5_sched_if;
    logic       req0_valid;
    logic       req0_ready;
    logic [4:0] req0_a;
    logic [4:0] req0_b;
    logic       req1_valid;
    logic       req1_ready;
    logic [4:0] req1_a;
    logic [4:0] req1_b;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] out_p;
    logic       out_id;
    logic       busy;

    modport slave (
        input  req0_valid, req0_a, req0_b,
        input  req1_valid, req1_a, req1_b,
        input  out_ready,
        output req0_ready, req1_ready,
        output out_valid, out_p, out_id, busy
    );

    modport master (
        output req0_valid, req0_a, req0_b,
        output req1_valid, req1_a, req1_b,
        output out_ready,
        input  req0_ready, req1_ready,
        input  out_valid, out_p, out_id, busy
    );
endinterface

// File: rtl/mul5_sched.sv
// mul5_sched
// Round-robin scheduler and sequencer for a 5x5 unsigned shift-accumulate
// multiplier unfolded by three. One job is in flight at a time: it is
// accepted in IDLE, multiplier bits 0..2 are accumulated in P0, bits 3..4 in
// P1, and the product is presented in DONE until the consumer takes it.
// Ports:
//   clk   : clock, everything updates on the rising edge
//   reset : synchronous, active-high
//   bus   : mul5_sched_if.slave (operand requests, product result, busy)
module mul5_sched (
    input logic          clk,
    input logic          reset,
    mul5_sched_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        P0   = 2'd1,
        P1   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] a_q, a_d;
    logic [4:0] b_q, b_d;
    logic       id_q, id_d;
    logic [9:0] acc_q, acc_d;
    logic       last_grant_q, last_grant_d;
    logic       out_valid_q, out_valid_d;
    logic [9:0] out_p_q, out_p_d;
    logic       out_id_q, out_id_d;

    logic       grant0;
    logic       grant1;
    logic [9:0] a_ext;
    logic [9:0] pp_p0;
    logic [9:0] pp_p1;
    logic [9:0] sum_p1;

    // Grants are only offered in IDLE and never while reset is high. Under
    // contention the requester that was not served last wins.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == IDLE && !reset) begin
            grant0 = bus.req0_valid && (!bus.req1_valid || last_grant_q);
            grant1 = bus.req1_valid && (!bus.req0_valid || !last_grant_q);
        end
    end

    // Partial products for the two phases, zero-extended to the 10-bit
    // accumulator width; 31*31 fits, so no carry out is ever lost.
    assign a_ext  = {5'd0, a_q};
    assign pp_p0  = (b_q[0] ? a_ext        : 10'd0)
                  + (b_q[1] ? (a_ext << 1) : 10'd0)
                  + (b_q[2] ? (a_ext << 2) : 10'd0);
    assign pp_p1  = (b_q[3] ? (a_ext << 3) : 10'd0)
                  + (b_q[4] ? (a_ext << 4) : 10'd0);
    assign sum_p1 = acc_q + pp_p1;

    // Next-state and datapath: everything holds unless the current state
    // says otherwise. The final sum is written straight into out_p so the
    // product is visible the cycle DONE is entered.
    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        id_d         = id_q;
        acc_d        = acc_q;
        last_grant_d = last_grant_q;
        out_valid_d  = out_valid_q;
        out_p_d      = out_p_q;
        out_id_d     = out_id_q;
        case (state_q)
            IDLE: begin
                if (grant0 || grant1) begin
                    a_d          = grant1 ? bus.req1_a : bus.req0_a;
                    b_d          = grant1 ? bus.req1_b : bus.req0_b;
                    id_d         = grant1;
                    acc_d        = 10'd0;
                    last_grant_d = grant1;
                    state_d      = P0;
                end
            end
            P0: begin
                acc_d   = acc_q + pp_p0;
                state_d = P1;
            end
            P1: begin
                acc_d       = sum_p1;
                out_p_d     = sum_p1;
                out_id_d    = id_q;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register. Reset discards any job in flight; last_grant comes up
    // as 1 so requester 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            a_q          <= 5'd0;
            b_q          <= 5'd0;
            id_q         <= 1'b0;
            acc_q        <= 10'd0;
            last_grant_q <= 1'b1;
            out_valid_q  <= 1'b0;
            out_p_q      <= 10'd0;
            out_id_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            id_q         <= id_d;
            acc_q        <= acc_d;
            last_grant_q <= last_grant_d;
            out_valid_q  <= out_valid_d;
            out_p_q      <= out_p_d;
            out_id_q     <= out_id_d;
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_p      = out_p_q;
    assign bus.out_id     = out_id_q;
    assign bus.busy       = (state_q != IDLE);

endmodule

// File: doc/mul5_sched.md
# mul5_sched

Two-requester scheduler and sequencer for the 5-bit unfolded (J=3) shift-accumulate multiplier datapath. It arbitrates round-robin between two operand sources using valid/ready handshakes and locks the multiply engine to one job at a time. The engine runs b's bits three per cycle in phase P0 and two per cycle in phase P1. The block returns a 10-bit product tagged with the requester id over a valid/ready result port. It sits between the DSP front-end operand queues and the accumulator/writeback stage.

## Interface
- No parameters; all widths are fixed (operands 5 bits, product 10 bits, 2 requesters).
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state on a rising edge where reset=1
- req0_valid  in  1  requester 0 has an operand pair
- req0_ready  out  1  requester 0 pair accepted this cycle when valid&ready
- req0_a, req0_b  in  5 each  requester 0 multiplicand / multiplier (unsigned)
- req1_valid, req1_ready, req1_a, req1_b  same as requester 0, for requester 1
- out_valid  out  1  product available
- out_ready  in  1  consumer accepts product this cycle when valid&ready
- out_p  out  10  unsigned product a*b
- out_id  out  1  requester that issued the product
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, P0, P1, DONE. Reset state is IDLE.
- IDLE:
  - Grant logic is combinational. If exactly one reqN_valid is high, reqN_ready=1.
  - If both are high, the requester that is not last_grant gets ready. The other ready stays 0.
  - If neither is high, both readies are 0.
  - On handshake: capture a, b, and id into operand registers, clear acc to 0, set last_grant=id, go to P0.
- P0: acc <= acc + (b[0]?a:0) + (b[1]?a<<1:0) + (b[2]?a<<2:0). Go to P1.
- P1: acc <= acc + (b[3]?a<<3:0) + (b[4]?a<<4:0). Load out_p with the resulting sum, load out_id, set out_valid=1. Go to DONE.
- DONE: hold out_valid, out_p, and out_id stable. On out_valid&out_ready, clear out_valid and go to IDLE.
- Both readies are 0 in P0, P1, and DONE. Inputs are ignored outside IDLE.
- Arithmetic:
  - All adds are 10-bit unsigned, and partial products are zero-extended to 10 bits.
  - No overflow is possible, since the maximum is 31*31=961 < 1024.
- After a result is consumed, out_p and out_id keep their last values. Only out_valid drops.
- last_grant resets to 1, so req0 wins the first contention.

## Timing
- Handshake in IDLE at cycle T, then P0 at T+1, P1 at T+2.
- out_valid=1 from T+3 (DONE) until the cycle of out_ready=1, inclusive.
- Latency from accept to result: 3 cycles.
- Minimum issue interval: 4 cycles. If out_ready is held high, the next accept is at T+4 in IDLE.
- busy=1 during T+1 through the out-handshake cycle. busy=0 in IDLE.
- Reset values: req0_ready=0, req1_ready=0, out_valid=0, out_p=0, out_id=0, busy=0, last_grant=1, acc=0, FSM=IDLE.
- readies are forced to 0 while reset=1.
- Reset mid-operation (P0, P1, or DONE):
  - The job is discarded and no result is produced.
  - Outputs go to reset values on that edge.
  - Neither requester is acknowledged again for the lost job.
- A request that deasserts valid before it is granted is simply not taken. No state changes.
- Simultaneous valid on both requesters with out_ready back-to-back: grants alternate 0,1,0,1…

## Test plan
- Single job: req0 a=23, b=19 handshake at T → out_valid at T+3, out_p=437, out_id=0. busy high T+1..T+3.
- Extremes: a=31, b=31 → out_p=961. Then a=0, b=31 → 0. Then a=31, b=0 → 0. Then a=1, b=16 → 16 (P1-only bit).
- Contention: both valid from first cycle after reset, out_ready=1 constant.
  - Order is req0(a=5, b=6 → 30), req1(a=7, b=9 → 63), req0, req1.
  - Accepts occur every 4 cycles.
  - The non-granted ready is 0 in every cycle.
- Backpressure: out_ready=0 for 6 cycles after out_valid rises (a=12, b=11).
  - out_p stays 132, out_id stays stable, out_valid stays 1, both readies stay 0.
  - Release out_ready → IDLE next cycle.
- Reset in P1 (a=20, b=25): reset asserted one cycle.
  - Next cycle shows out_valid=0, out_p=0, busy=0.
  - A subsequent req1 a=3, b=3 → 9 with id=1 at +3.
- Fairness after idle: req1 served alone, then both valid → req0 granted first.
